// File: rtl/apb_mem_slave_if.sv
// APB3/APB4 bus bundle between one master select line and one memory slave.
// Signals:
//   PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT : master -> slave
//   PRDATA, PREADY, PSLVERR                            : slave -> master
// Modports: master (drives the request side), slave (drives the response side).
interface apb_mem_slave_if #(
  parameter int unsigned P_DWIDTH = 32
);
  localparam int unsigned PStrb = P_DWIDTH / 8;

  logic                PSEL;
  logic [31:0]         PADDR;
  logic                PENABLE;
  logic                PWRITE;
  logic [P_DWIDTH-1:0] PWDATA;
  logic [PStrb-1:0]    PSTRB;
  logic [2:0]          PPROT;
  logic [P_DWIDTH-1:0] PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3/APB4 word-addressed memory slave with programmable wait states, byte
// strobes and an error response for out-of-range or non-secure accesses.
// Ports:
//   PCLK   : clock, all logic on the rising edge
//   PRESET : synchronous active-high reset
//   bus    : APB slave modport (request in, PRDATA/PREADY/PSLVERR out)
// PRDATA is registered at the read setup edge; PREADY and PSLVERR are
// combinational from registered state and PENABLE.
module apb_mem_slave #(
  parameter int unsigned P_DWIDTH        = 32,
  parameter int unsigned P_STRB          = P_DWIDTH / 8,
  parameter int unsigned P_SIZE_IN_BYTES = 1024,
  parameter logic [31:0] P_ADDR_START    = 32'h0000_0000,
  parameter int unsigned P_DELAY         = 0,
  parameter bit          P_STRB_EN       = 1'b1,
  parameter bit          P_SECURE        = 1'b0
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_mem_slave_if.slave    bus
);

  localparam int unsigned Words  = P_SIZE_IN_BYTES / P_STRB;
  localparam int unsigned IdxW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned OffLsb = $clog2(P_STRB);

  typedef enum logic [1:0] {StIdle, StWait, StComplete} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [P_DWIDTH-1:0] prdata_q, prdata_d;
  logic [P_DWIDTH-1:0] mem_q [Words];

  logic [31:0]         offset;
  logic [IdxW-1:0]     idx_now;
  logic                err_now;
  logic                setup;
  logic                pready;
  logic                we;
  logic [P_STRB-1:0]   eff_strb;

  // 32-bit unsigned subtraction: addresses below the base wrap to a huge
  // offset and are caught by the range check as well.
  assign offset  = bus.PADDR - P_ADDR_START;
  assign idx_now = offset[OffLsb +: IdxW];
  assign err_now = (offset >= 32'(P_SIZE_IN_BYTES)) || (bus.PADDR < P_ADDR_START) ||
                   (P_SECURE && bus.PPROT[1]);
  assign setup   = bus.PSEL && !bus.PENABLE;
  assign pready  = (state_q == StWait) && (cnt_q == 4'd0) && bus.PENABLE;
  assign eff_strb = P_STRB_EN ? bus.PSTRB : {P_STRB{1'b1}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    unique case (state_q)
      StIdle, StComplete: begin
        if (state_q == StComplete) state_d = StIdle;
        // PSEL with PENABLE already high here is a protocol violation: ignored.
        if (setup) begin
          state_d = StWait;
          cnt_d   = 4'(P_DELAY);
          err_d   = err_now;
          idx_d   = idx_now;
          if (!bus.PWRITE) prdata_d = err_now ? '0 : mem_q[idx_now];
        end
      end
      StWait: begin
        if (!bus.PSEL) begin
          state_d = StIdle;  // master abort, nothing committed
        end else if (bus.PENABLE) begin
          if (cnt_q == 4'd0) begin
            state_d = StComplete;
            we      = bus.PWRITE && !err_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
    end
  end

  // Memory is deliberately not reset; reset only blocks a pending commit.
  always_ff @(posedge PCLK) begin
    if (we && !PRESET) begin
      for (int k = 0; k < int'(P_STRB); k++) begin
        if (eff_strb[k]) mem_q[idx_q][8*k +: 8] <= bus.PWDATA[8*k +: 8];
      end
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready && err_q;

  logic unused_sig;
  assign unused_sig = ^{bus.PPROT[2], bus.PPROT[0], bus.PSTRB, offset};

endmodule
